ex_stage: RTL and testbench
===========================

# ex_stage

Parametrised execute stage for the pipelined MIPS-style core. It sits between the ID/EX and EX/MEM boundaries and merges operand/destination selection, a W-bit ALU, branch compare and branch-target generation. It adds an iterative multiplier and a registered, stall-able EX/MEM output with valid/ready handshake and flush. The single-cycle combinational ALU path is replaced by this block.

## Interface
- W, 32, datapath width; at least 8, power of two
- RW, 5, register-address width
- SW, $clog2(W), shift-amount width (derived)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of in-flight op and output register
- in_valid  in  1  ID/EX holds a valid op
- in_ready  out  1  stage accepts an op this cycle
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 BEQ, 10 BNE, 11 MUL; 12–15 undefined
- a, b, imm  in  W each  rs value, rt value, sign-extended immediate
- pc_plus4  in  W  PC of the op + 4
- alu_src, reg_dst  in  1 each  operand-B select (1 = imm); destination select (1 = rd)
- rt, rd  in  RW each  candidate destinations
- out_valid  out  1  EX/MEM register holds a result
- out_ready  in  1  MEM consumes the result this cycle
- result  out  W  ALU/MUL result
- reg_write  out  1  result is to be written back
- dest_reg  out  RW  write-back register
- branch_taken  out  1  branch resolved taken
- branch_target  out  W  pc_plus4 + (imm << 2), modulo 2^W

## Operation
- Operand B is `alu_src ? imm : b`. Destination is `reg_dst ? rd : rt`.
- ADD and SUB wrap modulo 2^W. SLT produces 1 or 0, signed compare.
- Shifts shift operand B by a[SW-1:0]. SRA replicates the sign bit.
- BEQ and BNE:
  - Compare a with b; the raw b is used regardless of alu_src.
  - Register branch_taken and branch_target. result=0, reg_write=0, dest_reg=0.
- Undefined ops: result=0, reg_write=0, branch_taken=0. out_valid is still produced.
- MUL produces the low W bits of the unsigned product a × operand B. It uses a shift-add iterator: one multiplier bit per cycle.
- FSM:
  - IDLE: an accepted non-MUL op loads the output register directly. An accepted MUL latches its operands, dest and count=W, then goes to BUSY.
  - BUSY: count decrements each cycle. When count reaches 0, go to DONE.
  - DONE: when the output register is free (!out_valid || out_ready), load the product (reg_write=1) and go to IDLE. Otherwise hold.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- An op is accepted when in_valid && in_ready.
- The output register holds all outputs stable while out_valid && !out_ready.
- flush: clears out_valid, reg_write and branch_taken, and forces IDLE. It aborts a MUL in BUSY or DONE. Same-cycle in_valid is not accepted. flush has priority over out_ready and over completion.
- reset: every output register goes to 0, state goes to IDLE, count goes to 0. in_ready reads 1 in the cycle after reset deasserts. Reset has priority over flush.

## Timing
- Non-MUL latency is 1: accepted at edge k, out_valid=1 after edge k.
- Back-to-back non-MUL throughput is one op per cycle while out_ready=1.
- MUL accepted at edge k: product loads at edge k+W+1 if the output register is free, so out_valid=1 after that edge. in_ready=0 from after edge k until the product is loaded.
- Simultaneous out_ready and acceptance in the same cycle: the old result is consumed and the new one loads at the same edge, with no bubble.
- Outputs change only on clk edges. in_ready is combinational from state, out_valid, out_ready and flush.

## Test plan
- Reset for 2 cycles, then release -> out_valid=0, result=0, branch_taken=0, in_ready=1.
- ADD a=0xFFFFFFFF, b=2, alu_src=0, reg_dst=1, rd=7 -> next cycle: result=0x00000001, dest_reg=7, reg_write=1. Then SRA b=0x80000000 by a=4 -> result=0xF8000000.
- BEQ a=b=5, pc_plus4=0x100, imm=0xFFFFFFFF -> branch_taken=1, branch_target=0x000000FC, reg_write=0. BNE with the same operands -> branch_taken=0.
- MUL a=1234, imm=5678, alu_src=1, out_ready=1 -> in_ready=0 for W+1 cycles. result=7006652 appears W+1 edges after acceptance.
- Stall: hold out_ready=0 with a result valid -> outputs stable and in_ready=0. A MUL completing during the stall waits in DONE and loads on the cycle out_ready returns to 1.
- Assert flush mid-MUL at BUSY count=10 -> out_valid=0, state IDLE, in_ready=1 next cycle, and no stale product ever appears.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand/destination select, W-bit ALU, branch resolve and an
// iterative shift-add multiplier behind a stall-able EX/MEM register.
module ex_stage #(
    parameter int W  = 32,
    parameter int RW = 5,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  imm,
    input  logic [W-1:0]  pc_plus4,
    input  logic          alu_src,
    input  logic          reg_dst,
    input  logic [RW-1:0] rt,
    input  logic [RW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic          reg_write,
    output logic [RW-1:0] dest_reg,
    output logic          branch_taken,
    output logic [W-1:0]  branch_target
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_BEQ = 4'd9;
    localparam logic [3:0] OP_BNE = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  acc;
    logic [RW-1:0] mul_dest;

    logic [W-1:0]  opb;
    logic [RW-1:0] dest_sel;
    logic [W-1:0]  alu_res;
    logic          alu_we;
    logic          alu_dest_en;
    logic          br_taken;
    logic [W-1:0]  target;
    logic [SW-1:0] shamt;
    logic          free;
    logic          accept;

    assign free     = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && free && !flush;
    assign accept   = in_valid && in_ready;
    assign shamt    = a[SW-1:0];
    assign target   = pc_plus4 + {imm[W-3:0], 2'b00};

    // Operand selection and single-cycle ALU / branch compare.
    always_comb begin
        opb         = alu_src ? imm : b;
        dest_sel    = reg_dst ? rd : rt;
        alu_res     = {W{1'b0}};
        alu_we      = 1'b0;
        alu_dest_en = 1'b0;
        br_taken    = 1'b0;
        case (op)
            OP_ADD: begin alu_res = a + opb;       alu_we = 1'b1; alu_dest_en = 1'b1; end
            OP_SUB: begin alu_res = a - opb;       alu_we = 1'b1; alu_dest_en = 1'b1; end
            OP_AND: begin alu_res = a & opb;       alu_we = 1'b1; alu_dest_en = 1'b1; end
            OP_OR:  begin alu_res = a | opb;       alu_we = 1'b1; alu_dest_en = 1'b1; end
            OP_XOR: begin alu_res = a ^ opb;       alu_we = 1'b1; alu_dest_en = 1'b1; end
            OP_SLT: begin
                alu_res     = {{(W-1){1'b0}}, ($signed(a) < $signed(opb))};
                alu_we      = 1'b1;
                alu_dest_en = 1'b1;
            end
            OP_SLL: begin alu_res = opb << shamt;  alu_we = 1'b1; alu_dest_en = 1'b1; end
            OP_SRL: begin alu_res = opb >> shamt;  alu_we = 1'b1; alu_dest_en = 1'b1; end
            OP_SRA: begin
                alu_res     = W'($signed(opb) >>> shamt);
                alu_we      = 1'b1;
                alu_dest_en = 1'b1;
            end
            // Branches compare against the raw rt value, never the immediate.
            OP_BEQ: br_taken = (a == b);
            OP_BNE: br_taken = (a != b);
            default: br_taken = 1'b0;
        endcase
    end

    // Multiplier FSM and EX/MEM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= {CW{1'b0}};
            mcand         <= {W{1'b0}};
            mplier        <= {W{1'b0}};
            acc           <= {W{1'b0}};
            mul_dest      <= {RW{1'b0}};
            out_valid     <= 1'b0;
            result        <= {W{1'b0}};
            reg_write     <= 1'b0;
            dest_reg      <= {RW{1'b0}};
            branch_taken  <= 1'b0;
            branch_target <= {W{1'b0}};
        end else if (flush) begin
            state        <= IDLE;
            count        <= {CW{1'b0}};
            out_valid    <= 1'b0;
            reg_write    <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && op == OP_MUL) begin
                        mcand    <= a;
                        mplier   <= opb;
                        acc      <= {W{1'b0}};
                        mul_dest <= dest_sel;
                        count    <= CNT_FULL;
                        state    <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end else begin
                        acc <= acc;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state <= DONE;
                    end else begin
                        state <= BUSY;
                    end
                end
                DONE: begin
                    if (free) begin
                        state <= IDLE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept && op != OP_MUL) begin
                out_valid     <= 1'b1;
                result        <= alu_res;
                reg_write     <= alu_we;
                dest_reg      <= alu_dest_en ? dest_sel : {RW{1'b0}};
                branch_taken  <= br_taken;
                branch_target <= target;
            end else if (state == DONE && free) begin
                out_valid     <= 1'b1;
                result        <= acc;
                reg_write     <= 1'b1;
                dest_reg      <= mul_dest;
                branch_taken  <= 1'b0;
                branch_target <= {W{1'b0}};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage: expectations are queued at issue
// and compared when MEM consumes each result.
module tb_ex_stage;
    localparam int W  = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a, b, imm, pc_plus4;
    logic          alu_src, reg_dst;
    logic [RW-1:0] rt, rd;
    logic          out_valid, out_ready;
    logic [W-1:0]  result;
    logic          reg_write;
    logic [RW-1:0] dest_reg;
    logic          branch_taken;
    logic [W-1:0]  branch_target;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0]  res;
        logic          rw;
        logic [RW-1:0] dest;
        logic          tk;
        logic [W-1:0]  tgt;
        logic          is_br;
        logic          chk_dest;
    } exp_t;

    exp_t q[$];

    ex_stage #(.W(W), .RW(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .a(a), .b(b), .imm(imm),
        .pc_plus4(pc_plus4), .alu_src(alu_src), .reg_dst(reg_dst),
        .rt(rt), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .reg_write(reg_write), .dest_reg(dest_reg),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model, written independently of the RTL structure.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] ra,
                                   input logic [W-1:0] rb, input logic [W-1:0] ri,
                                   input logic [W-1:0] pc, input logic s,
                                   input logic dsel, input logic [RW-1:0] t,
                                   input logic [RW-1:0] d);
        exp_t e;
        logic [W-1:0] bv;
        logic [63:0]  prod;
        int sh;
        bv = s ? ri : rb;
        sh = int'(ra[4:0]);
        e.res = '0; e.rw = 1'b0; e.dest = dsel ? d : t; e.tk = 1'b0;
        e.tgt = pc + ri * 32'd4; e.is_br = 1'b0; e.chk_dest = 1'b1;
        case (o)
            4'd0: begin e.res = ra + bv; e.rw = 1'b1; end
            4'd1: begin e.res = ra + ~bv + 32'd1; e.rw = 1'b1; end
            4'd2: begin e.res = ra & bv; e.rw = 1'b1; end
            4'd3: begin e.res = ra | bv; e.rw = 1'b1; end
            4'd4: begin e.res = ra ^ bv; e.rw = 1'b1; end
            4'd5: begin
                e.res = (ra[31] != bv[31]) ? {31'd0, ra[31]} : {31'd0, (ra < bv)};
                e.rw = 1'b1;
            end
            4'd6: begin e.res = bv << sh; e.rw = 1'b1; end
            4'd7: begin e.res = bv >> sh; e.rw = 1'b1; end
            4'd8: begin
                e.res = (bv >> sh) | (bv[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                e.rw = 1'b1;
            end
            4'd9:  begin e.tk = (ra == rb); e.dest = '0; e.is_br = 1'b1; end
            4'd10: begin e.tk = (ra != rb); e.dest = '0; e.is_br = 1'b1; end
            4'd11: begin prod = 64'(ra) * 64'(bv); e.res = prod[31:0]; e.rw = 1'b1; end
            default: e.chk_dest = 1'b0;
        endcase
        return e;
    endfunction

    // Drive one op from a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] ra, input logic [W-1:0] rb,
                         input logic [W-1:0] ri, input logic [W-1:0] pc, input logic s,
                         input logic dsel, input logic [RW-1:0] t, input logic [RW-1:0] d);
        int n;
        op = o; a = ra; b = rb; imm = ri; pc_plus4 = pc;
        alu_src = s; reg_dst = dsel; rt = t; rd = d; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'(in_ready), 64'd1);
        end else begin
            q.push_back(model(o, ra, rb, ri, pc, s, dsel, t, d));
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    // Scoreboard: compare each result in the cycle MEM consumes it.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && !flush && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected", 64'(result), 64'hDEAD);
            end else begin
                e = q.pop_front();
                chk("sb_result", 64'(result), 64'(e.res));
                chk("sb_reg_write", 64'(reg_write), 64'(e.rw));
                chk("sb_taken", 64'(branch_taken), 64'(e.tk));
                if (e.chk_dest) chk("sb_dest", 64'(dest_reg), 64'(e.dest));
                if (e.is_br) chk("sb_target", 64'(branch_target), 64'(e.tgt));
            end
        end
    end

    initial begin
        logic [W-1:0] held_res;
        logic [RW-1:0] held_dest;
        int n;
        bit stale;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = '0; b = '0; imm = '0; pc_plus4 = '0;
        alu_src = 1'b0; reg_dst = 1'b0; rt = '0; rd = '0;
        @(negedge clk); cycles(2);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_taken", 64'(branch_taken), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Back-to-back ALU ops with MEM always ready.
        out_ready = 1'b1;
        issue(4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b1, 5'd3, 5'd7);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_result", 64'(result), 64'd1);
        issue(4'd8, 32'd4, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd9, 5'd1);
        chk("sra_result", 64'(result), 64'hF800_0000);
        issue(4'd1, 32'd5, 32'd0, 32'd7, 32'd0, 1'b1, 1'b0, 5'd4, 5'd2);
        issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd30);
        issue(4'd3, 32'h0000_00F0, 32'd0, 32'h0000_000F, 32'd0, 1'b1, 1'b0, 5'd31, 5'd2);
        issue(4'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd5, 5'd6);
        issue(4'd5, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8, 5'd6);
        issue(4'd5, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8, 5'd6);
        issue(4'd6, 32'd31, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 5'd10, 5'd6);
        issue(4'd7, 32'd36, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 5'd11, 5'd6);
        issue(4'd13, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 5'd12, 5'd13);
        chk("undef_valid", 64'(out_valid), 64'd1);
        issue(4'd9, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h100, 1'b1, 1'b1, 5'd1, 5'd2);
        chk("beq_target", 64'(branch_target), 64'h0000_00FC);
        issue(4'd10, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h100, 1'b1, 1'b1, 5'd1, 5'd2);

        // Multiply latency and in_ready back-pressure.
        issue(4'd11, 32'd1234, 32'd0, 32'd5678, 32'd0, 1'b1, 1'b1, 5'd0, 5'd17);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            #1; chk("mul_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); @(negedge clk); n++;
        end
        chk("mul_latency", 64'(n), 64'(W + 1));
        cycles(1);

        // Stall: outputs frozen while MEM is not ready.
        out_ready = 1'b0;
        issue(4'd0, 32'd100, 32'd23, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd21);
        in_valid = 1'b0;
        held_res = result; held_dest = dest_reg;
        cycles(3);
        #1;
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_result", 64'(result), 64'(held_res));
        chk("stall_dest", 64'(dest_reg), 64'(held_dest));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        cycles(1);

        // Product loads into a free register and is held while stalled.
        out_ready = 1'b0;
        issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 5'd25, 5'd0);
        in_valid = 1'b0;
        cycles(W + 3);
        #1;
        chk("mulhold_valid", 64'(out_valid), 64'd1);
        chk("mulhold_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        cycles(1);

        // flush beats out_ready on a stalled result.
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd0);
        in_valid = 1'b0;
        flush = 1'b1; out_ready = 1'b1;
        cycles(1);
        flush = 1'b0;
        void'(q.pop_back());
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_reg_write", 64'(reg_write), 64'd0);
        @(negedge clk);

        // Abort a multiply mid-iteration; same-cycle op must be refused.
        issue(4'd11, 32'd77, 32'd99, 32'd0, 32'd0, 1'b0, 1'b0, 5'd6, 5'd0);
        in_valid = 1'b0;
        cycles(W - 10);
        flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd9; b = 32'd9;
        #1;
        chk("flush_blocks_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        void'(q.pop_back());
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        stale = 1'b0;
        repeat (W + 8) begin
            @(posedge clk); @(negedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("abort_no_stale", 64'(stale), 64'd0);
        @(negedge clk);
        issue(4'd1, 32'd10, 32'd20, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd4);
        in_valid = 1'b0;
        cycles(3);
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
